// File: rtl/idma_sched_pkg.sv
// Shared types and helpers for the iDMA channel scheduler.
// Transfer IDs wrap all-ones -> 1 so that ID 0 always means "none".
package idma_sched_pkg;

  localparam int unsigned ChanIdxMaxW = 8;
  localparam int unsigned IdMaxW      = 32;

  typedef logic [ChanIdxMaxW-1:0] chan_idx_t;
  typedef logic [IdMaxW-1:0]      tf_id_t;

  // Increment an ID held in the low w bits, skipping 0 on wrap.
  function automatic tf_id_t id_inc(tf_id_t id, int unsigned w);
    tf_id_t m;
    m = '1;
    m = m >> (IdMaxW - w);
    if ((id & m) == m) begin
      return tf_id_t'(1);
    end
    return (id + tf_id_t'(1)) & m;
  endfunction

endpackage

// File: rtl/idma_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last
// accepted one; the pointer only moves on the advance strobe.
module idma_rr_arbiter
  import idma_sched_pkg::*;
#(
  parameter int NumChannels = 4,
  localparam int CW = $clog2(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   adv_i,
  output logic [NumChannels-1:0] gnt_o,
  output logic [CW-1:0]          idx_o
);

  logic [CW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 1; k <= NumChannels; k++) begin
      c = (int'(ptr_q) + k) % NumChannels;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= CW'(NumChannels - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/idma_channel_scheduler.sv
// Shares one iDMA backend among channels: RR issue with global IDs,
// in-order owner tracking FIFO, per-channel completion reporting.
module idma_channel_scheduler
  import idma_sched_pkg::*;
#(
  parameter int NumChannels    = 4,
  parameter int IdWidth        = 8,
  parameter int MaxOutstanding = 8,
  localparam int CW = $clog2(NumChannels),
  localparam int PW = $clog2(MaxOutstanding),
  localparam int OW = PW + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumChannels-1:0]              req_valid_i,
  output logic [NumChannels-1:0]              req_ready_o,
  output logic                                issue_valid_o,
  input  logic                                issue_ready_i,
  output logic [CW-1:0]                       issue_chan_o,
  output logic [IdWidth-1:0]                  issue_id_o,
  input  logic                                retire_i,
  output logic [NumChannels-1:0]              done_valid_o,
  output logic [IdWidth-1:0]                  done_id_o,
  output logic [NumChannels-1:0][IdWidth-1:0] chan_completed_o,
  output logic [OW-1:0]                       outstanding_o,
  output logic                                err_o
);

  typedef logic [IdWidth-1:0] id_t;
  typedef logic [CW-1:0]      ch_t;

  function automatic id_t inc(id_t v);
    return id_t'(id_inc(tf_id_t'(v), IdWidth));
  endfunction

  logic [NumChannels-1:0] grant;
  ch_t                    grant_idx;
  logic                   full, empty, accept, pop;

  ch_t     fifo_q [MaxOutstanding];
  ch_t     fifo_d [MaxOutstanding];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [OW-1:0] cnt_q, cnt_d;
  id_t     next_id_q, next_id_d;
  id_t     comp_id_q, comp_id_d;
  id_t     done_id_q, done_id_d;
  logic    err_q, err_d;
  logic [NumChannels-1:0] done_valid_q, done_valid_d;
  logic [NumChannels-1:0][IdWidth-1:0] chan_comp_q, chan_comp_d;

  idma_rr_arbiter #(
    .NumChannels(NumChannels)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .adv_i (accept),
    .gnt_o (grant),
    .idx_o (grant_idx)
  );

  assign full  = (cnt_q == OW'(MaxOutstanding));
  assign empty = (cnt_q == '0);

  // No same-cycle slot reuse: a full FIFO blocks issue even on retire.
  assign issue_valid_o = (|req_valid_i) & ~full & ~rst_i;
  assign accept        = issue_valid_o & issue_ready_i;
  assign pop           = retire_i & ~empty;

  assign req_ready_o  = accept ? grant : '0;
  assign issue_chan_o = grant_idx;
  assign issue_id_o   = next_id_q;

  assign done_valid_o     = done_valid_q;
  assign done_id_o        = done_id_q;
  assign chan_completed_o = chan_comp_q;
  assign outstanding_o    = cnt_q;
  assign err_o            = err_q;

  always_comb begin
    ch_t head;
    id_t cid;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    next_id_d    = next_id_q;
    comp_id_d    = comp_id_q;
    done_id_d    = done_id_q;
    done_valid_d = '0;
    err_d        = 1'b0;
    chan_comp_d  = chan_comp_q;
    head         = fifo_q[rptr_q];
    cid          = inc(comp_id_q);

    if (accept) begin
      fifo_d[wptr_q] = grant_idx;
      wptr_d         = wptr_q + 1'b1;
      next_id_d      = inc(next_id_q);
    end

    if (pop) begin
      rptr_d            = rptr_q + 1'b1;
      comp_id_d         = cid;
      done_id_d         = cid;
      done_valid_d[head] = 1'b1;
      chan_comp_d[head]  = cid;
    end else if (retire_i) begin
      err_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      next_id_q    <= id_t'(2);
      comp_id_q    <= id_t'(1);
      done_id_q    <= '0;
      done_valid_q <= '0;
      err_q        <= 1'b0;
      chan_comp_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      next_id_q    <= next_id_d;
      comp_id_q    <= comp_id_d;
      done_id_q    <= done_id_d;
      done_valid_q <= done_valid_d;
      err_q        <= err_d;
      chan_comp_q  <= chan_comp_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: doc/idma_channel_scheduler.md
# idma_channel_scheduler

Shares one iDMA backend between `NumChannels` frontend requesters. Each cycle it picks one requester by round-robin and tags the granted transfer with a global transfer ID. It records the owning channel of every outstanding transfer in an in-order tracking FIFO. On each backend retirement it reports the completed ID to the owning channel. It sits between the per-channel frontends and the single backend request and response port.

## Interface

Parameters:
- `NumChannels`, 4: number of requesting channels (≥2).
- `IdWidth`, 8: transfer ID width (≥2).
- `MaxOutstanding`, 8: tracking FIFO depth (power of two, ≥2).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NumChannels  channel c requests issue.
- `req_ready_o`  out  NumChannels  one-hot grant, asserted when the transfer is accepted.
- `issue_valid_o`  out  1  request to backend.
- `issue_ready_i`  in  1  backend accepts.
- `issue_chan_o`  out  $clog2(NumChannels)  granted channel.
- `issue_id_o`  out  IdWidth  ID of the transfer being issued.
- `retire_i`  in  1  backend completed the oldest outstanding transfer (in order).
- `done_valid_o`  out  NumChannels  one-cycle completion pulse, one-hot.
- `done_id_o`  out  IdWidth  ID completed (valid with `done_valid_o`).
- `chan_completed_o`  out  NumChannels×IdWidth  last completed ID per channel.
- `outstanding_o`  out  $clog2(MaxOutstanding)+1  transfers in flight.
- `err_o`  out  1  one-cycle pulse: retire while empty.

## Operation

ID counters:
- `next_id` resets to 2 and increments on each accepted issue.
- `completed_id` resets to 1 and increments on each valid retire.
- Wrap rule for both counters: all-ones → 1, skipping 0. ID 0 is never issued and means "none".

Arbitration:
- Round-robin over `req_valid_i`, starting at the channel after the last granted one.
- The pointer resets to NumChannels-1, so channel 0 has first priority.
- The pointer advances only on an accepted issue (`issue_valid_o & issue_ready_i`).
- A stalled grant holds its channel and ID stable.

Issue path:
- `issue_valid_o = |req_valid_i & !full`.
- `issue_id_o = next_id`.
- `req_ready_o[c] = grant[c] & issue_ready_i & !full`.
- On acceptance, the granted channel index is pushed into the FIFO.

Retire path:
- A valid retire (`retire_i & !empty`) pops the FIFO head channel h.
- The following cycle, `done_valid_o[h]` pulses with `done_id_o` = the completed ID.
- `chan_completed_o[h]` is updated to that ID.
- A retire while empty is ignored: no pop, no counter change, `err_o` pulses the following cycle.

Boundary conditions:
- Full: `issue_valid_o`=0 even when a retire occurs in the same cycle. There is no same-cycle slot reuse.
- Issue and retire in the same cycle while not empty and not full: push and pop both occur, and `outstanding_o` is unchanged.
- Issue and retire in the same cycle while empty: the retire errs, the issue proceeds.
- `req_valid_i` dropping while stalled changes the grant. Requesters must hold valid until ready (AXI-style). This block does not check it.

## Timing

- Issue path is combinational from `req_valid_i`/`issue_ready_i` to the outputs, with zero-cycle latency.
- Completion latency: 1 cycle from `retire_i` to `done_valid_o`/`done_id_o`/`err_o`, all registered.
- `outstanding_o`, `chan_completed_o` and the counters update on the edge after the event.
- Reset values (a sync reset asserted mid-operation flushes the FIFO and all in-flight state):
  - `done_valid_o`=0, `done_id_o`=0, `err_o`=0.
  - `chan_completed_o`=0 for all channels.
  - `outstanding_o`=0.
  - `next_id`=2, `completed_id`=1.
  - RR pointer = NumChannels-1.
- While `rst_i` is asserted, `issue_valid_o` and `req_ready_o` are forced to 0.

## Structure

- Package `idma_sched_pkg`: `chan_idx_t`, `tf_id_t`, the `id_inc` wrap function (all-ones → 1).
- Sub-module `idma_rr_arbiter`:
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant and grant index.
  - Owns the pointer, with synchronous active-high reset.
- The tracking FIFO is inline: channel index array, read/write pointers and count.

## Test plan

- Reset, then channel 0 alone issues with `issue_ready_i`=1 → `issue_id_o`=2, `issue_chan_o`=0. Retire → next cycle `done_valid_o`=0001, `done_id_o`=2, `chan_completed_o[0]`=2.
- All four channels hold valid with ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3 with IDs 2..9. `req_ready_o` stays low the cycle after the FIFO is full, after 8 issues.
- Fill the FIFO (`outstanding_o`=8), then assert issue and retire in the same cycle → no acceptance, `outstanding_o`=7. The next cycle the issue is accepted.
- IdWidth=2: issue 4 transfers → IDs 2,3,1,2. Retire 4 → `done_id_o` 2,3,1,2.
- Retire while empty → `err_o` pulses once, `outstanding_o` stays 0, `done_valid_o`=0.
- Assert `rst_i` with 3 outstanding → all outputs at their reset values the next cycle, and the first new issue carries ID 2.
